// File: rtl/load_latency_hazard_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : load_latency_hazard_unit_pkg
// Description : Shared constants and helpers for the load-latency hazard unit.
// Revision    : 1.0
// ============================================================================
package load_latency_hazard_unit_pkg;

    localparam int AW       = 5;
    localparam int MAX_SRC  = 8;
    localparam int LOAD_LAT = 1;
    localparam logic [AW-1:0] REG_ZERO = '0;
    localparam int CW = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;

    // Counter width for an arbitrary latency; always at least one bit.
    function automatic int cnt_width(input int lat);
        return (lat > 1) ? $clog2(lat) : 1;
    endfunction

    function automatic logic [AW-1:0] load_slice(input logic [MAX_SRC*AW-1:0] addrs,
                                                 input int i);
        return addrs[i*AW +: AW];
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_latency_hazard_unit_load_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : load_scoreboard
// Description : Per-register countdown of loads still in flight beyond EX.
// Revision    : 1.0
// ============================================================================
module load_scoreboard #(
    parameter int AW       = 5,
    parameter int NUM_REGS = 32,
    parameter int LOAD_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ld_valid,
    input  logic [AW-1:0]       ld_rd,
    input  logic                freeze,
    output logic [NUM_REGS-1:0] busy
);
    import load_latency_hazard_unit_pkg::*;

    localparam int              SB_CW  = cnt_width(LOAD_LAT);
    localparam logic [SB_CW-1:0] RELOAD = SB_CW'(LOAD_LAT - 1);

    logic [SB_CW-1:0] cnt_q [NUM_REGS];
    logic [SB_CW-1:0] cnt_d [NUM_REGS];

    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_d[r] = cnt_q[r];
            if (!freeze && (cnt_q[r] != '0)) begin
                cnt_d[r] = cnt_q[r] - SB_CW'(1);
            end
        end
        // A new load overrides the decrement of its own entry.
        if (!freeze && ld_valid && (LOAD_LAT > 1)) begin
            cnt_d[ld_rd] = RELOAD;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
        end
    end

    generate
        for (genvar gr = 0; gr < NUM_REGS; gr++) begin : g_busy
            assign busy[gr] = (cnt_q[gr] != '0);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/load_latency_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_latency_hazard_unit
// Description : ID-stage load-use / mispredict / freeze control with stall stats.
// Revision    : 1.0
// ============================================================================
module load_latency_hazard_unit #(
    parameter int AW       = 5,
    parameter int NUM_REGS = 32,
    parameter int NUM_SRC  = 2,
    parameter int LOAD_LAT = 1,
    parameter int STAT_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_SRC*AW-1:0] rs_addr,
    input  logic [NUM_SRC-1:0]    rs_used,
    input  logic [AW-1:0]         rd_ex,
    input  logic                  MemRead_ex,
    input  logic                  branch_taken,
    input  logic                  branch_prediction,
    input  logic                  mem_stall,
    output logic                  nop,
    output logic                  flush,
    output logic                  IF_ID_Write,
    output logic                  PC_Write,
    output logic [NUM_SRC-1:0]    hazard_src,
    output logic [STAT_W-1:0]     stall_count
);
    import load_latency_hazard_unit_pkg::*;

    logic [NUM_REGS-1:0] w_busy;
    logic                w_ld_ex;
    logic [NUM_SRC-1:0]  w_hit;
    logic                w_luh;
    logic [STAT_W-1:0]   stall_count_q;
    logic [STAT_W-1:0]   stall_count_d;

    assign w_ld_ex = MemRead_ex && (rd_ex != AW'(REG_ZERO));

    load_scoreboard #(
        .AW       (AW),
        .NUM_REGS (NUM_REGS),
        .LOAD_LAT (LOAD_LAT)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .ld_valid (w_ld_ex),
        .ld_rd    (rd_ex),
        .freeze   (mem_stall),
        .busy     (w_busy)
    );

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
            logic [AW-1:0] w_rs;
            assign w_rs       = rs_addr[gi*AW +: AW];
            assign w_hit[gi]  = rs_used[gi] && (w_rs != AW'(REG_ZERO)) &&
                                ((w_ld_ex && (w_rs == rd_ex)) || w_busy[w_rs]);
        end
    endgenerate

    assign w_luh = |w_hit;

    always_comb begin
        nop         = 1'b0;
        flush       = 1'b0;
        IF_ID_Write = 1'b1;
        PC_Write    = 1'b1;
        hazard_src  = '0;
        if (!rst) begin
            hazard_src = w_hit;
            // Freeze dominates: EX holds, so branch resolution waits too.
            if (mem_stall) begin
                IF_ID_Write = 1'b0;
                PC_Write    = 1'b0;
            end else if (branch_prediction != branch_taken) begin
                flush       = 1'b1;
                IF_ID_Write = 1'b0;
            end else if (w_luh) begin
                nop         = 1'b1;
                IF_ID_Write = 1'b0;
                PC_Write    = 1'b0;
            end
        end
    end

    always_comb begin
        stall_count_d = stall_count_q;
        if (nop && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + STAT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;

endmodule
`default_nettype wire

// File: tb/tb_load_latency_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_latency_hazard_unit
// Description : Three configurations driven in parallel against a timeline model.
// Revision    : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_load_latency_hazard_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  rs_addr;
    logic [1:0]  rs_used;
    logic [4:0]  rd_ex;
    logic        MemRead_ex;
    logic        branch_taken;
    logic        branch_prediction;
    logic        mem_stall;

    logic        nop_o  [3];
    logic        flush_o[3];
    logic        ifid_o [3];
    logic        pc_o   [3];
    logic [1:0]  hs_o   [3];
    logic [15:0] sc0;
    logic [15:0] sc1;
    logic [1:0]  sc2;

    int checks = 0;
    int errors = 0;

    // Model: a load's data is usable LOAD_LAT unfrozen cycles after its EX cycle.
    int   lat  [3] = '{1, 3, 3};
    int   scmax[3] = '{65535, 65535, 3};
    int   last [3][32];
    int   tick [3];
    int   exp_sc[3];
    logic e_nop[3];

    always #5 clk = ~clk;

    load_latency_hazard_unit #(.LOAD_LAT(1)) dut0 (
        .clk(clk), .rst(rst), .rs_addr(rs_addr), .rs_used(rs_used), .rd_ex(rd_ex),
        .MemRead_ex(MemRead_ex), .branch_taken(branch_taken),
        .branch_prediction(branch_prediction), .mem_stall(mem_stall),
        .nop(nop_o[0]), .flush(flush_o[0]), .IF_ID_Write(ifid_o[0]), .PC_Write(pc_o[0]),
        .hazard_src(hs_o[0]), .stall_count(sc0));

    load_latency_hazard_unit #(.LOAD_LAT(3)) dut1 (
        .clk(clk), .rst(rst), .rs_addr(rs_addr), .rs_used(rs_used), .rd_ex(rd_ex),
        .MemRead_ex(MemRead_ex), .branch_taken(branch_taken),
        .branch_prediction(branch_prediction), .mem_stall(mem_stall),
        .nop(nop_o[1]), .flush(flush_o[1]), .IF_ID_Write(ifid_o[1]), .PC_Write(pc_o[1]),
        .hazard_src(hs_o[1]), .stall_count(sc1));

    load_latency_hazard_unit #(.LOAD_LAT(3), .STAT_W(2)) dut2 (
        .clk(clk), .rst(rst), .rs_addr(rs_addr), .rs_used(rs_used), .rd_ex(rd_ex),
        .MemRead_ex(MemRead_ex), .branch_taken(branch_taken),
        .branch_prediction(branch_prediction), .mem_stall(mem_stall),
        .nop(nop_o[2]), .flush(flush_o[2]), .IF_ID_Write(ifid_o[2]), .PC_Write(pc_o[2]),
        .hazard_src(hs_o[2]), .stall_count(sc2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sc_of(input int k);
        case (k)
            0:       return {16'd0, sc0};
            1:       return {16'd0, sc1};
            default: return {30'd0, sc2};
        endcase
    endfunction

    task automatic check_dut(input int k);
        logic [1:0] hs;
        logic       ld, luh, en, ef, ei, ep;
        int         rs;
        ld = MemRead_ex && (rd_ex != 5'd0);
        for (int i = 0; i < 2; i++) begin
            rs    = int'(rs_addr[i*5 +: 5]);
            hs[i] = rs_used[i] && (rs != 0) &&
                    ((ld && (rs == int'(rd_ex))) || (tick[k] - last[k][rs] < lat[k]));
        end
        luh = |hs;
        en = 1'b0; ef = 1'b0; ei = 1'b1; ep = 1'b1;
        if (rst) begin
            hs = 2'b00;
        end else if (mem_stall) begin
            ei = 1'b0; ep = 1'b0;
        end else if (branch_prediction != branch_taken) begin
            ef = 1'b1; ei = 1'b0;
        end else if (luh) begin
            en = 1'b1; ei = 1'b0; ep = 1'b0;
        end
        e_nop[k] = en;
        chk($sformatf("d%0d_nop", k),   {31'd0, nop_o[k]},   {31'd0, en});
        chk($sformatf("d%0d_flush", k), {31'd0, flush_o[k]}, {31'd0, ef});
        chk($sformatf("d%0d_ifid", k),  {31'd0, ifid_o[k]},  {31'd0, ei});
        chk($sformatf("d%0d_pc", k),    {31'd0, pc_o[k]},    {31'd0, ep});
        chk($sformatf("d%0d_hsrc", k),  {30'd0, hs_o[k]},    {30'd0, hs});
        chk($sformatf("d%0d_stallcnt", k), sc_of(k), 32'(exp_sc[k]));
    endtask

    task automatic update_model(input int k);
        if (rst) begin
            for (int r = 0; r < 32; r++) last[k][r] = -1000;
            exp_sc[k] = 0;
        end else if (!mem_stall) begin
            if (MemRead_ex && (rd_ex != 5'd0)) last[k][rd_ex] = tick[k];
            tick[k]++;
            if (e_nop[k] && (exp_sc[k] < scmax[k])) exp_sc[k]++;
        end
    endtask

    task automatic drive(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [1:0] used, input logic [4:0] rd, input logic mr,
                         input logic bt, input logic bp, input logic ms);
        @(negedge clk);
        rst = r; rs_addr = {rs2, rs1}; rs_used = used; rd_ex = rd; MemRead_ex = mr;
        branch_taken = bt; branch_prediction = bp; mem_stall = ms;
        #1;
        for (int k = 0; k < 3; k++) check_dut(k);
    endtask

    task automatic edge_update();
        @(posedge clk);
        for (int k = 0; k < 3; k++) update_model(k);
    endtask

    task automatic cyc(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [1:0] used, input logic [4:0] rd, input logic mr,
                       input logic bt, input logic bp, input logic ms);
        drive(r, rs1, rs2, used, rd, mr, bt, bp, ms);
        edge_update();
    endtask

    task automatic do_reset();
        cyc(1, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1; rs_addr = '0; rs_used = '0; rd_ex = '0; MemRead_ex = 1'b0;
        branch_taken = 1'b0; branch_prediction = 1'b0; mem_stall = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick[k] = 0; exp_sc[k] = 0; e_nop[k] = 1'b0;
            for (int r = 0; r < 32; r++) last[k][r] = -1000;
        end

        // Reset forces defaults even with a live hazard pattern on the inputs.
        drive(1, 5, 0, 2'b11, 5, 1, 0, 0, 0);
        chk("rst_nop",  {31'd0, nop_o[1]},  32'd0);
        chk("rst_ifid", {31'd0, ifid_o[1]}, 32'd1);
        chk("rst_hsrc", {30'd0, hs_o[1]},   32'd0);
        edge_update();
        do_reset();

        // Classic single-bubble load-use.
        drive(0, 5, 0, 2'b11, 5, 1, 0, 0, 0);
        chk("tp1_nop",  {31'd0, nop_o[0]},  32'd1);
        chk("tp1_pc",   {31'd0, pc_o[0]},   32'd0);
        chk("tp1_ifid", {31'd0, ifid_o[0]}, 32'd0);
        chk("tp1_hsrc", {30'd0, hs_o[0]},   32'd1);
        edge_update();
        drive(0, 5, 0, 2'b11, 5, 0, 0, 0, 0);
        chk("tp1_rel_nop", {31'd0, nop_o[0]}, 32'd0);
        chk("tp1_rel_pc",  {31'd0, pc_o[0]},  32'd1);
        edge_update();

        // LOAD_LAT=3: three bubbles then release.
        do_reset();
        cyc(0, 7, 0, 2'b01, 7, 1, 0, 0, 0);
        cyc(0, 7, 0, 2'b01, 0, 0, 0, 0, 0);
        drive(0, 7, 0, 2'b01, 0, 0, 0, 0, 0);
        chk("tp2_nop3", {31'd0, nop_o[1]}, 32'd1);
        edge_update();
        drive(0, 7, 0, 2'b01, 0, 0, 0, 0, 0);
        chk("tp2_release", {31'd0, nop_o[1]}, 32'd0);
        chk("tp2_stallcnt", {16'd0, sc1}, 32'd3);
        edge_update();

        // Freeze in the middle of the window.
        do_reset();
        cyc(0, 7, 0, 2'b01, 7, 1, 0, 0, 0);
        drive(0, 7, 0, 2'b01, 0, 0, 0, 0, 1);
        chk("tp3_frz_nop", {31'd0, nop_o[1]}, 32'd0);
        chk("tp3_frz_pc",  {31'd0, pc_o[1]},  32'd0);
        edge_update();
        cyc(0, 7, 0, 2'b01, 0, 0, 0, 0, 0);
        cyc(0, 7, 0, 2'b01, 0, 0, 0, 0, 0);
        drive(0, 7, 0, 2'b01, 0, 0, 0, 0, 0);
        chk("tp3_release",  {31'd0, nop_o[1]}, 32'd0);
        chk("tp3_stallcnt", {16'd0, sc1},      32'd3);
        edge_update();

        // Mispredict beats a load-use hit on rs2.
        do_reset();
        drive(0, 0, 4, 2'b10, 4, 1, 1, 0, 0);
        chk("tp4_flush", {31'd0, flush_o[1]}, 32'd1);
        chk("tp4_nop",   {31'd0, nop_o[1]},   32'd0);
        chk("tp4_pc",    {31'd0, pc_o[1]},    32'd1);
        chk("tp4_ifid",  {31'd0, ifid_o[1]},  32'd0);
        edge_update();
        drive(0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
        chk("tp4_stallcnt", {16'd0, sc1}, 32'd0);
        edge_update();

        // x0 and unused sources never hit.
        drive(0, 0, 0, 2'b11, 0, 1, 0, 0, 0);
        chk("tp5_x0", {30'd0, hs_o[1]}, 32'd0);
        edge_update();
        drive(0, 6, 0, 2'b10, 6, 1, 0, 0, 0);
        chk("tp5_unused", {30'd0, hs_o[1]}, 32'd0);
        edge_update();

        // Reset clears an in-flight entry.
        do_reset();
        cyc(0, 0, 0, 2'b00, 9, 1, 0, 0, 0);
        do_reset();
        drive(0, 9, 0, 2'b01, 0, 0, 0, 0, 0);
        chk("tp6_nop",      {31'd0, nop_o[1]}, 32'd0);
        chk("tp6_stallcnt", {16'd0, sc1},      32'd0);
        edge_update();

        // Five stall cycles: narrow counter saturates.
        do_reset();
        for (int n = 0; n < 5; n++) cyc(0, 3, 0, 2'b01, 3, 1, 0, 0, 0);
        drive(0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
        chk("sat_wide",   {16'd0, sc0}, 32'd5);
        chk("sat_narrow", {30'd0, sc2}, 32'd3);
        edge_update();

        // Randomized traffic over a small register set to provoke hits.
        for (int n = 0; n < 400; n++) begin
            logic bp_r;
            bp_r = 1'($urandom_range(0, 1));
            cyc(1'($urandom_range(0, 49) == 0),
                5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)),
                ($urandom_range(0, 9) == 0) ? ~bp_r : bp_r, bp_r,
                1'($urandom_range(0, 6) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
